// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard/forwarding unit.
// Tag entries carry a fixed-width rd field wide enough for any supported REG_AW.
package hazard_pkg;

  localparam int unsigned MAX_REG_AW = 16;
  localparam int unsigned FWD_SRC_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } tag_t;

  // Width of a forwarding select able to name the regfile plus every in-flight stage.
  function automatic int unsigned fwd_sel_w(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shift register of destination tags, one entry per in-flight stage between ID and RF write.
// A zero tag (invalid) is inserted whenever the ID instruction does not advance.
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    insert,
  input  tag_t                    tag_in,
  output tag_t [PIPE_DEPTH:1]     tags
);

  tag_t [PIPE_DEPTH:1] tags_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags_q <= '0;
    end else begin
      tags_q[1] <= insert ? tag_in : '0;
      for (int k = 2; k <= int'(PIPE_DEPTH); k++) begin
        tags_q[k] <= tags_q[k-1];
      end
    end
  end

  assign tags = tags_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard detector: forwarding selects, load-use stall, redirect flush, stall counter.
// Define HAZARD_FWD_EN for forwarding; otherwise every RAW hazard stalls until writeback.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned ECALL_REG  = 17,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  id_valid,
  input  logic                                  id_is_ecall,
  input  logic [REG_AW-1:0]                     id_rs1,
  input  logic [REG_AW-1:0]                     id_rs2,
  input  logic                                  id_use_rs1,
  input  logic                                  id_use_rs2,
  input  logic [REG_AW-1:0]                     id_rd,
  input  logic                                  id_reg_write,
  input  logic                                  id_is_load,
  input  logic                                  ex_redirect,
  output logic                                  stall_if,
  output logic                                  bubble_id,
  output logic                                  flush_if_id,
  output logic [fwd_sel_w(PIPE_DEPTH)-1:0]      fwd_sel_rs1,
  output logic [fwd_sel_w(PIPE_DEPTH)-1:0]      fwd_sel_rs2,
  output logic [CNT_W-1:0]                      stall_cycles
);

  localparam int unsigned SEL_W = fwd_sel_w(PIPE_DEPTH);

  if (REG_AW > MAX_REG_AW || REG_AW < 1) begin : g_bad_reg_aw
    $error("hazard_fwd_unit: REG_AW out of range");
  end
  if (LOAD_STAGE < 1 || LOAD_STAGE > PIPE_DEPTH + 1 || PIPE_DEPTH < 1) begin : g_bad_stage
    $error("hazard_fwd_unit: LOAD_STAGE/PIPE_DEPTH out of range");
  end

  tag_t [PIPE_DEPTH:1]   tags;
  tag_t                  tag_in;
  logic                  insert;
  logic [MAX_REG_AW-1:0] src1, src2;
  logic                  use1, use2;
  logic                  hit1, hit2;
  logic                  ld1, ld2;
  logic [SEL_W-1:0]      k1, k2;
  logic                  hazard;
  logic [CNT_W-1:0]      cnt_q;

  function automatic logic tag_match(input tag_t t, input logic [MAX_REG_AW-1:0] src,
                                     input logic use_src);
    return use_src & t.valid & t.reg_write & (t.rd == src) & (src != '0);
  endfunction

  // ecall implicitly reads ECALL_REG through rs1; an empty ID slot reads nothing.
  assign src1 = id_is_ecall ? MAX_REG_AW'(ECALL_REG) : MAX_REG_AW'(id_rs1);
  assign src2 = MAX_REG_AW'(id_rs2);
  assign use1 = id_valid & (id_use_rs1 | id_is_ecall);
  assign use2 = id_valid & id_use_rs2;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    k1   = '0;
    k2   = '0;
    for (int k = int'(PIPE_DEPTH); k >= 1; k--) begin
      if (tag_match(tags[k], src1, use1)) begin
        hit1 = 1'b1;
        k1   = SEL_W'(k);
        ld1  = tags[k].is_load;
      end
      if (tag_match(tags[k], src2, use2)) begin
        hit2 = 1'b1;
        k2   = SEL_W'(k);
        ld2  = tags[k].is_load;
      end
    end
  end

`ifdef HAZARD_FWD_EN
  logic lu1, lu2;

  assign lu1    = hit1 & ld1 & (int'(k1) < int'(LOAD_STAGE));
  assign lu2    = hit2 & ld2 & (int'(k2) < int'(LOAD_STAGE));
  assign hazard = lu1 | lu2;

  always_comb begin
    fwd_sel_rs1 = SEL_W'(FWD_SRC_RF);
    fwd_sel_rs2 = SEL_W'(FWD_SRC_RF);
    if (reset && !hazard) begin
      if (hit1) fwd_sel_rs1 = k1;
      if (hit2) fwd_sel_rs2 = k2;
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd  = ^{k1, k2, ld1, ld2};
  assign hazard      = hit1 | hit2;
  assign fwd_sel_rs1 = SEL_W'(FWD_SRC_RF);
  assign fwd_sel_rs2 = SEL_W'(FWD_SRC_RF);
`endif

  // Redirect wins over a stall: the stalled instruction is wrong-path anyway.
  assign stall_if    = reset & hazard & ~ex_redirect;
  assign bubble_id   = reset & (hazard | ex_redirect);
  assign flush_if_id = reset & ex_redirect;

  assign insert = id_valid & ~stall_if & ~ex_redirect;

  always_comb begin
    tag_in           = '0;
    tag_in.valid     = 1'b1;
    tag_in.rd        = MAX_REG_AW'(id_rd);
    tag_in.reg_write = id_reg_write;
    tag_in.is_load   = id_is_load;
  end

  hazard_tag_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .insert (insert),
    .tag_in (tag_in),
    .tags   (tags)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (stall_if && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus random traffic against an issue-history model.
// Follows HAZARD_FWD_EN so the same file checks either build.
module tb_hazard_fwd_unit;

  localparam int DEPTH = 2;
  localparam int LOADS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_is_ecall, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect;
  logic       stall_if, bubble_id, flush_if_id;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_fwd_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_is_ecall  (id_is_ecall),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .stall_if     (stall_if),
    .bubble_id    (bubble_id),
    .flush_if_id  (flush_if_id),
    .fwd_sel_rs1  (fwd_sel_rs1),
    .fwd_sel_rs2  (fwd_sel_rs2),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Model: history of instructions that left ID, stamped with the edge they issued on.
  typedef struct {
    int         issue;
    logic [4:0] rd;
    bit         rw;
    bit         ld;
  } inst_t;

  inst_t       hist[$];
  int          cyc = 0;
  int unsigned m_cnt = 0;
  bit          e_stall, e_bubble, e_flush;
  logic [1:0]  e_sel1, e_sel2;

  // Stage of the youngest in-flight writer of src (0 = none); stage = edges since issue + 1.
  task automatic youngest(input logic [4:0] src, input bit use_src, output int stage,
                          output bit ld);
    stage = 0;
    ld    = 0;
    foreach (hist[i]) begin
      int s;
      s = cyc - hist[i].issue + 1;
      if (use_src && src != 0 && hist[i].rw && hist[i].rd == src && s >= 1 && s <= DEPTH &&
          (stage == 0 || s < stage)) begin
        stage = s;
        ld    = hist[i].ld;
      end
    end
  endtask

  task automatic model_eval();
    int s1, s2;
    bit l1, l2, haz;
    youngest(id_is_ecall ? 5'd17 : id_rs1, id_valid && (id_use_rs1 || id_is_ecall), s1, l1);
    youngest(id_rs2, id_valid && id_use_rs2, s2, l2);
`ifdef HAZARD_FWD_EN
    haz    = (s1 > 0 && l1 && s1 < LOADS) || (s2 > 0 && l2 && s2 < LOADS);
    e_sel1 = haz ? 2'd0 : 2'(s1);
    e_sel2 = haz ? 2'd0 : 2'(s2);
`else
    haz    = (s1 > 0) || (s2 > 0);
    e_sel1 = 2'd0;
    e_sel2 = 2'd0;
`endif
    e_stall  = haz && !ex_redirect;
    e_bubble = haz || ex_redirect;
    e_flush  = ex_redirect;
    if (!reset) begin
      {e_stall, e_bubble, e_flush} = 3'b000;
      e_sel1 = 2'd0;
      e_sel2 = 2'd0;
    end
  endtask

  // Advance one clock and retire the model; returns at the following negedge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reset) begin
      cyc++;
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (id_valid && !e_stall && !ex_redirect)
        hist.push_back('{issue: cyc, rd: id_rd, rw: id_reg_write, ld: id_is_load});
      while (hist.size() > 0 && cyc - hist[0].issue + 1 > DEPTH) void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input bit ec, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                        input bit rw, input bit ld, input bit redir);
    id_valid = v; id_is_ecall = ec; id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd; id_reg_write = rw; id_is_load = ld;
    ex_redirect = redir;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    hist.delete();
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set_id(1, 0, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 1);
    if ({stall_if, bubble_id, flush_if_id} !== 3'b000) begin
      $display("FAIL reset_ctrl got %b want 000", {stall_if, bubble_id, flush_if_id});
    end else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'd0) $display("FAIL reset_cnt got %0d want 0", stall_cycles);
    else n_pass++;
    n_chk++;
    do_reset();
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    tick();
    set_id(1, 0, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd1)
      $display("FAIL fwd_k1 got stall=%b sel=%0d want stall=0 sel=1", stall_if, fwd_sel_rs1);
    else n_pass++;
    n_chk++;
    tick();
    set_id(1, 0, 5'd5, 1, 0, 0, 5'd7, 1, 0, 0);
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd2)
      $display("FAIL fwd_k2 got stall=%b sel=%0d want stall=0 sel=2", stall_if, fwd_sel_rs1);
    else n_pass++;
    n_chk++;
`else
    for (int i = 0; i < 2; i++) begin
      if (stall_if !== 1'b1 || bubble_id !== 1'b1)
        $display("FAIL nofwd_stall%0d got stall=%b bubble=%b want 1 1", i, stall_if, bubble_id);
      else n_pass++;
      n_chk++;
      tick();
    end
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd0)
      $display("FAIL nofwd_release got stall=%b sel=%0d want 0 0", stall_if, fwd_sel_rs1);
    else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'd2) $display("FAIL nofwd_cnt got %0d want 2", stall_cycles);
    else n_pass++;
    n_chk++;
`endif
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 5'd5, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 5'd5, 1, 5'd8, 1, 0, 0);
    if (stall_if !== 1'b1 || bubble_id !== 1'b1 || fwd_sel_rs2 !== 2'd0)
      $display("FAIL lu_stall got stall=%b bubble=%b sel=%0d want 1 1 0", stall_if, bubble_id,
               fwd_sel_rs2);
    else n_pass++;
    n_chk++;
    tick();
`ifdef HAZARD_FWD_EN
    if (stall_if !== 1'b0 || bubble_id !== 1'b0 || fwd_sel_rs2 !== 2'd2)
      $display("FAIL lu_after got stall=%b bubble=%b sel=%0d want 0 0 2", stall_if, bubble_id,
               fwd_sel_rs2);
    else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'd1) $display("FAIL lu_cnt got %0d want 1", stall_cycles);
    else n_pass++;
    n_chk++;
`endif
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 5'd0, 1, 0, 0);
    tick();
    set_id(1, 0, 5'd0, 1, 5'd0, 1, 5'd5, 1, 0, 0);
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd0 || fwd_sel_rs2 !== 2'd0)
      $display("FAIL x0 got stall=%b sel=%0d/%0d want 0 0/0", stall_if, fwd_sel_rs1, fwd_sel_rs2);
    else n_pass++;
    n_chk++;
    tick();
    set_id(1, 0, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    tick();
    set_id(1, 0, 5'd5, 1, 0, 0, 5'd9, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd1)
      $display("FAIL youngest got stall=%b sel=%0d want 0 1", stall_if, fwd_sel_rs1);
`else
    if (stall_if !== 1'b1 || fwd_sel_rs1 !== 2'd0)
      $display("FAIL youngest got stall=%b sel=%0d want 1 0", stall_if, fwd_sel_rs1);
`endif
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_redirect_ecall();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 5'd5, 1, 1, 0);
    tick();
    set_id(1, 0, 5'd5, 1, 0, 0, 5'd9, 1, 0, 1);
    if ({stall_if, flush_if_id, bubble_id} !== 3'b011)
      $display("FAIL redirect got stall/flush/bubble=%b want 011",
               {stall_if, flush_if_id, bubble_id});
    else n_pass++;
    n_chk++;
    tick();
    set_id(1, 0, 0, 0, 5'd9, 1, 5'd10, 1, 0, 0);
    if (stall_if !== 1'b0 || fwd_sel_rs2 !== 2'd0)
      $display("FAIL flushed_tag got stall=%b sel=%0d want 0 0", stall_if, fwd_sel_rs2);
    else n_pass++;
    n_chk++;
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 5'd17, 1, 0, 0);
    tick();
    set_id(1, 1, 5'd3, 0, 0, 0, 5'd0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd1)
      $display("FAIL ecall got stall=%b sel=%0d want 0 1", stall_if, fwd_sel_rs1);
`else
    if (stall_if !== 1'b1)
      $display("FAIL ecall got stall=%b want 1", stall_if);
`endif
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 5'd5, 1, 1, 0);
    tick();
    set_id(1, 0, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0);
    tick();
    set_id(1, 0, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1);
    #2;
    reset = 1'b0;
    hist.delete();
    m_cnt = 0;
    #1;
    if ({stall_if, bubble_id, flush_if_id, fwd_sel_rs1, fwd_sel_rs2} !== 7'd0)
      $display("FAIL midreset_out got %b want 0000000",
               {stall_if, bubble_id, flush_if_id, fwd_sel_rs1, fwd_sel_rs2});
    else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'd0) $display("FAIL midreset_cnt got %0d want 0", stall_cycles);
    else n_pass++;
    n_chk++;
    @(negedge clk);
    reset = 1'b1;
    set_id(1, 0, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    if (stall_if !== 1'b0 || fwd_sel_rs1 !== 2'd0)
      $display("FAIL midreset_tags got stall=%b sel=%0d want 0 0", stall_if, fwd_sel_rs1);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(7) != 0, $urandom_range(9) == 0, 5'($urandom_range(7)),
             $urandom_range(1), 5'($urandom_range(7)), $urandom_range(1),
             ($urandom_range(3) == 0) ? 5'd17 : 5'($urandom_range(7)), $urandom_range(3) != 0,
             $urandom_range(2) == 0, $urandom_range(9) == 0);
      model_eval();
      if ({stall_if, bubble_id, flush_if_id} !== {e_stall, e_bubble, e_flush})
        $display("FAIL rnd_ctrl[%0d] got %b want %b", i, {stall_if, bubble_id, flush_if_id},
                 {e_stall, e_bubble, e_flush});
      else n_pass++;
      n_chk++;
      if (fwd_sel_rs1 !== e_sel1 || fwd_sel_rs2 !== e_sel2)
        $display("FAIL rnd_sel[%0d] got %0d/%0d want %0d/%0d", i, fwd_sel_rs1, fwd_sel_rs2,
                 e_sel1, e_sel2);
      else n_pass++;
      n_chk++;
      if (stall_cycles !== m_cnt)
        $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, stall_cycles, m_cnt);
      else n_pass++;
      n_chk++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_zero_reg();
    test_redirect_ecall();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
